fpu_sp_exp_aligner: RTL and testbench

//  Consumer end of the exponent comparator interface in the FP add/sub datapath.

---
 rtl/fpu_sp_exp_aligner.sv | 129 ++++++++++++
 tb/tb_fpu_sp_exp_aligner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sp_exp_aligner.sv
// Exponent aligner for the FP add/sub datapath: picks the larger operand and
// right-shifts the smaller mantissa by the exponent difference, keeping G/R/S bits.
// The shift is iterative, moving at most SHIFT_STEP bits per cycle.
module fpu_sp_exp_aligner #(
    parameter int unsigned EXP_W      = 8,
    parameter int unsigned MANT_W     = 24,
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXP_W-1:0]    exp_a,
    input  logic [EXP_W-1:0]    exp_b,
    input  logic [MANT_W-1:0]   mant_a,
    input  logic [MANT_W-1:0]   mant_b,
    input  logic [EXP_W-1:0]    diff,
    input  logic                sign,
    input  logic                overflow,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EXP_W-1:0]    exp_out,
    output logic [MANT_W-1:0]   mant_big,
    output logic [MANT_W+2:0]   mant_small_aligned,
    output logic                swapped
);

    localparam int unsigned EXT_W = MANT_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [EXP_W-1:0]    rem_q, rem_d;
    logic [EXT_W-1:0]    ext_d;
    logic [EXP_W-1:0]    exp_d;
    logic [MANT_W-1:0]   big_d;
    logic                swapped_d;
    logic                out_valid_d;
    logic                in_ready_d;

    logic                accept_c;
    logic                flush_c;
    logic [MANT_W-1:0]   small_c;
    logic [EXP_W-1:0]    k_c;
    logic [EXT_W-1:0]    mask_c;
    logic                sticky_c;

    // Next-state, datapath update and registered-output targets
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        ext_d       = mant_small_aligned;
        exp_d       = exp_out;
        big_d       = mant_big;
        swapped_d   = swapped;

        accept_c    = in_valid && in_ready;
        small_c     = sign ? mant_a : mant_b;
        // Any shift of EXT_W or more pushes every bit into sticky.
        flush_c     = overflow || (32'(diff) >= EXT_W);
        k_c         = (rem_q < EXP_W'(SHIFT_STEP)) ? rem_q : EXP_W'(SHIFT_STEP);
        mask_c      = ~({EXT_W{1'b1}} << k_c);
        sticky_c    = |(mant_small_aligned & mask_c);

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    exp_d     = sign ? exp_b : exp_a;
                    big_d     = sign ? mant_b : mant_a;
                    swapped_d = sign;
                    if (flush_c) begin
                        ext_d   = {{(EXT_W-1){1'b0}}, |small_c};
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        ext_d   = {small_c, 3'b000};
                        rem_d   = diff;
                        state_d = (diff == '0) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Old S bit sits inside the shifted-out field, so it folds into sticky.
                ext_d = (mant_small_aligned >> k_c) | {{(EXT_W-1){1'b0}}, sticky_c};
                rem_d = rem_q - k_c;
                if (rem_q == k_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            rem_q              <= '0;
            mant_small_aligned <= '0;
            exp_out            <= '0;
            mant_big           <= '0;
            swapped            <= 1'b0;
            out_valid          <= 1'b0;
            in_ready           <= 1'b0;
        end else begin
            state_q            <= state_d;
            rem_q              <= rem_d;
            mant_small_aligned <= ext_d;
            exp_out            <= exp_d;
            mant_big           <= big_d;
            swapped            <= swapped_d;
            out_valid          <= out_valid_d;
            in_ready           <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_fpu_sp_exp_aligner.sv
// Directed bench for fpu_sp_exp_aligner with hand-computed expected values.
module tb_fpu_sp_exp_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic [7:0]  diff;
    logic        sign;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [23:0] mant_big;
    logic [26:0] mant_small_aligned;
    logic        swapped;

    int tests  = 0;
    int failed = 0;

    fpu_sp_exp_aligner #(.EXP_W(8), .MANT_W(24), .SHIFT_STEP(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .exp_a              (exp_a),
        .exp_b              (exp_b),
        .mant_a             (mant_a),
        .mant_b             (mant_b),
        .diff               (diff),
        .sign               (sign),
        .overflow           (overflow),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .exp_out            (exp_out),
        .mant_big           (mant_big),
        .mant_small_aligned (mant_small_aligned),
        .swapped            (swapped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready (bounded), then present one bundle for a single accept edge
    task automatic accept(input string name, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [23:0] ma, input logic [23:0] mb, input logic [7:0] d,
                          input logic sg, input logic ov);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s in_ready timeout: got %b want 1", name, in_ready);
        end
        exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
        diff = d; sign = sg; overflow = ov; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Scramble inputs: they must not matter after the accept edge
        exp_a = 8'hFF; exp_b = 8'hEE; mant_a = 24'h123456; mant_b = 24'h654321;
        diff = 8'h00; sign = ~sg; overflow = 1'b0;
    endtask

    // Count edges since accept until out_valid, then check latency and payload
    task automatic wait_check(input string name, input int lat, input logic [7:0] e_exp,
                              input logic [23:0] e_big, input logic [26:0] e_small,
                              input logic e_sw);
        int edges = 1;
        while (!out_valid && edges < 100) begin
            tick();
            edges++;
        end
        tests++;
        if (edges !== lat || out_valid !== 1'b1) begin
            failed++;
            $display("FAIL %s latency: got %0d edges (valid=%b) want %0d", name, edges, out_valid, lat);
        end
        tests++;
        if (exp_out !== e_exp || mant_big !== e_big || mant_small_aligned !== e_small || swapped !== e_sw) begin
            failed++;
            $display("FAIL %s payload: got exp=%h big=%h small=%h sw=%b want exp=%h big=%h small=%h sw=%b",
                     name, exp_out, mant_big, mant_small_aligned, swapped, e_exp, e_big, e_small, e_sw);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            failed++;
            $display("FAIL %s in_ready in DONE: got %b want 0", name, in_ready);
        end
    endtask

    // Complete the output handshake and confirm return to IDLE
    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s after handshake: got valid=%b ready=%b want valid=0 ready=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0; diff = '0; sign = 1'b0; overflow = 1'b0;
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || exp_out !== 8'h0 || mant_big !== 24'h0 ||
            mant_small_aligned !== 27'h0 || swapped !== 1'b0) begin
            failed++;
            $display("FAIL reset: got valid=%b ready=%b exp=%h big=%h small=%h sw=%b want all 0",
                     out_valid, in_ready, exp_out, mant_big, mant_small_aligned, swapped);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release: in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_no_shift();
        accept("diff0", 8'h10, 8'h10, 24'h800000, 24'hC00000, 8'd0, 1'b0, 1'b0);
        wait_check("diff0", 1, 8'h10, 24'h800000, 27'h6000000, 1'b0);
        handshake("diff0");
    endtask

    task automatic test_shift_swap();
        accept("diff5", 8'h10, 8'h15, 24'h800001, 24'hA00000, 8'd5, 1'b1, 1'b0);
        wait_check("diff5", 3, 8'h15, 24'hA00000, 27'h0200001, 1'b1);
        handshake("diff5");
    endtask

    task automatic test_flush();
        accept("ovf", 8'h90, 8'h10, 24'hFFFFFF, 24'h800000, 8'h80, 1'b0, 1'b1);
        wait_check("ovf", 1, 8'h90, 24'hFFFFFF, 27'h0000001, 1'b0);
        handshake("ovf");
        accept("diff27", 8'h30, 8'h15, 24'h900000, 24'h800000, 8'd27, 1'b0, 1'b0);
        wait_check("diff27", 1, 8'h30, 24'h900000, 27'h0000001, 1'b0);
        handshake("diff27");
        accept("flush_zero", 8'h05, 8'h40, 24'h000000, 24'hABCDEF, 8'd59, 1'b1, 1'b0);
        wait_check("flush_zero", 1, 8'h40, 24'hABCDEF, 27'h0000000, 1'b1);
        handshake("flush_zero");
    endtask

    task automatic test_step_boundary();
        accept("diff8", 8'h20, 8'h18, 24'hF00000, 24'h000081, 8'd8, 1'b0, 1'b0);
        wait_check("diff8", 3, 8'h20, 24'hF00000, 27'h0000005, 1'b0);
        handshake("diff8");
    endtask

    task automatic test_backpressure();
        accept("stall", 8'h10, 8'h15, 24'h800001, 24'hA00000, 8'd5, 1'b1, 1'b0);
        wait_check("stall", 3, 8'h15, 24'hA00000, 27'h0200001, 1'b1);
        // A second, different bundle is offered throughout the stall
        exp_a = 8'h01; exp_b = 8'h02; mant_a = 24'h111111; mant_b = 24'h222222;
        diff = 8'd0; sign = 1'b0; overflow = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || exp_out !== 8'h15 || mant_big !== 24'hA00000 ||
                mant_small_aligned !== 27'h0200001 || swapped !== 1'b1) begin
                failed++;
                $display("FAIL stall_hold cycle %0d: got valid=%b ready=%b exp=%h big=%h small=%h sw=%b",
                         i, out_valid, in_ready, exp_out, mant_big, mant_small_aligned, swapped);
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL stall_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL stall_no_second_accept: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        accept("rst_mid", 8'h30, 8'h1C, 24'hC00000, 24'hFFFFFF, 8'd20, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || exp_out !== 8'h0 || mant_big !== 24'h0 ||
            mant_small_aligned !== 27'h0 || swapped !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid outputs: got valid=%b exp=%h big=%h small=%h sw=%b want 0",
                     out_valid, exp_out, mant_big, mant_small_aligned, swapped);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid recover: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                failed++;
                $display("FAIL rst_mid stray valid at cycle %0d: got %b want 0", i, out_valid);
            end
        end
        accept("post_rst", 8'h22, 8'h22, 24'h812345, 24'h800001, 8'd0, 1'b1, 1'b0);
        wait_check("post_rst", 1, 8'h22, 24'h800001, 27'h4091A28, 1'b1);
        handshake("post_rst");
    endtask

    initial begin
        test_reset();
        test_no_shift();
        test_shift_swap();
        test_flush();
        test_step_boundary();
        test_backpressure();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
